bram_be: RTL
============

// Module: bram_be
// PURPOSE
//  Parametrised single-port block RAM, next generation of the CPU's program/data store.
//  Adds over the fixed 16x16K store: configurable width/depth, per-byte write enables,
//  selectable read-during-write mode, optional output register, and a post-reset clear
//  engine with busy/valid signalling. Sits between the sequencer and its memory bus.
// PARAMETERS
//  WIDTH     16  data word width in bits; multiple of 8
//  BITS      14  address width; depth = 1<<BITS words
//  RDW_MODE  0   same-address read+write in one cycle: 0 = old data, 1 = new (merged) data
//  OUT_REG   0   1 = extra output register stage; read latency 1+OUT_REG
//  CLEAR     1   1 = zero every word after reset release; 0 = no clear, contents undefined
// PORTS
//  clk       in   1          rising-edge clock
//  rst_n     in   1          async active-low reset
//  wren_n    in   1          active-low write strobe
//  oen_n     in   1          active-low read strobe
//  be_n      in   WIDTH/8    active-low byte-lane enables for writes; lane i = bits 8i+7:8i
//  address   in   BITS       word address
//  data_in   in   WIDTH      write data
//  data_out  out  WIDTH      read data, registered
//  valid_out out  1          one-cycle pulse aligned with each new data_out
//  busy      out  1          high while the clear engine runs; strobes ignored
// BEHAVIOUR
//  Reset (async assert, sync release): data_out=0, valid_out=0, pipeline valid=0,
//   clear counter=0. busy=CLEAR. Array is never reset directly; this keeps BRAM inference.
//  FSM: CLEAR -> RUN. Entered at reset as CLEAR if CLEAR=1, otherwise as RUN.
//   CLEAR: each cycle writes 0 to word[cnt], all lanes, then cnt++.
//    Leaves after word DEPTH-1, so busy is high for exactly DEPTH cycles after release.
//   RUN: normal access. Terminal state until next reset.
//  rst_n asserted mid-clear: FSM and counter return to CLEAR/0; the clear restarts from word 0.
//  While busy: wren_n/oen_n ignored. No write occurs, valid_out stays 0, data_out holds.
//  Write (RUN, wren_n=0): at the edge, lanes with be_n[i]=0 take data_in lane i.
//   Other lanes keep their contents. be_n all ones -> no change.
//  Read (RUN, oen_n=0): data_out = word[address] one edge later (OUT_REG=0) or two (OUT_REG=1).
//   valid_out is high in the same cycle data_out updates.
//  No read: data_out holds its last value; valid_out=0. Back-to-back reads give one word/cycle.
//  Read+write same cycle, same address:
//   RDW_MODE=0 -> returns the pre-write word.
//   RDW_MODE=1 -> returns the post-write word (enabled lanes new, others old).
//   Different addresses: independent.
//  OUT_REG=1: the second stage loads only when stage-1 valid is set, so holds are preserved.
//  Address range: BITS wide, so every value is in range; no wrap logic is needed.
// STRUCTURE
//  Shared package bram_pkg: RDW_OLD=0/RDW_NEW=1, state encoding
//   (ST_CLEAR=1'b0, ST_RUN=1'b1), lanes function WIDTH/8.
//  Sub-module bram_be_array: the bare array. Byte-lane write loop plus a registered read.
//   No reset, so the tool infers block RAM. The top holds the FSM, clear counter, muxing,
//   RDW merge and output stage.
// TESTING
//  1 CLEAR=1, BITS=4: release rst_n -> busy high exactly 16 cycles.
//    Then reads of 0..15 all return 0 with valid_out.
//  2 Write 16'hA5C3 @0x3, be_n=2'b00; read 0x3 -> data_out=A5C3 after 1 (OUT_REG=0)
//    and 2 (OUT_REG=1) edges.
//  3 Over A5C3 @0x3, write 16'hFFFF with be_n=2'b10; read -> 16'hA5FF.
//  4 Same-cycle write 16'h1234 + read @0x3 (holds A5FF) -> RDW_MODE=0 gives A5FF;
//    RDW_MODE=1 gives 1234. Next read gives 1234.
//  5 Drop rst_n at clear cycle 7, release -> busy again 16 cycles.
//    Strobes during busy: no write, valid_out=0.
//  6 Read @0x1 then idle 5 cycles -> valid_out pulses once; data_out holds its value.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared definitions for the byte-enable block RAM: read-during-write modes,
// controller state encoding and a byte-lane helper.
package bram_pkg;

  localparam bit RDW_OLD = 1'b0;
  localparam bit RDW_NEW = 1'b1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  function automatic int lanes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/bram_be_array.sv
// Bare single-port storage: per-lane write enables and a registered read.
// Deliberately unreset so synthesis maps it onto block RAM.
module bram_be_array #(
  parameter int WIDTH = 16,
  parameter int BITS  = 14,
  parameter int LANES = WIDTH / 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [LANES-1:0] be_i,
  input  logic [BITS-1:0]  addr_i,
  input  logic [WIDTH-1:0] wdat_i,
  output logic [WIDTH-1:0] rdat_o
);

  localparam int DEPTH = 1 << BITS;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdat_q;

  // Read samples the array before this edge's write lands: old-data behaviour.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdat_i[8*i +: 8];
      end
    end
    if (re_i) rdat_q <= mem_q[addr_i];
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/bram_be.sv
// Single-port RAM with byte enables, post-reset clear engine, selectable
// read-during-write result and optional output register.
module bram_be
  import bram_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int BITS     = 14,
  parameter bit RDW_MODE = RDW_OLD,
  parameter bit OUT_REG  = 1'b0,
  parameter bit CLEAR    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wren_n,
  input  logic                    oen_n,
  input  logic [lanes(WIDTH)-1:0] be_n,
  input  logic [BITS-1:0]         address,
  input  logic [WIDTH-1:0]        data_in,
  output logic [WIDTH-1:0]        data_out,
  output logic                    valid_out,
  output logic                    busy
);

  localparam int     LANES    = lanes(WIDTH);
  localparam state_e ST_RESET = CLEAR ? ST_CLEAR : ST_RUN;

  state_e            state_q, state_d;
  logic [BITS-1:0]   cnt_q, cnt_d;

  logic              arr_we, arr_re;
  logic [LANES-1:0]  arr_be;
  logic [BITS-1:0]   arr_addr;
  logic [WIDTH-1:0]  arr_wdat, arr_rdat, wmask;

  logic              s1_vld_q, s1_vld_d;
  logic              seen_q, seen_d;
  logic              hit_q, hit_d;
  logic [WIDTH-1:0]  hmask_q, hmask_d;
  logic [WIDTH-1:0]  hdat_q, hdat_d;
  logic [WIDTH-1:0]  s1_dat;

  logic              s2_vld_q;
  logic [WIDTH-1:0]  s2_dat_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    arr_we   = 1'b0;
    arr_re   = 1'b0;
    arr_be   = '0;
    arr_addr = address;
    arr_wdat = data_in;
    if (state_q == ST_CLEAR) begin
      arr_we   = 1'b1;
      arr_be   = '1;
      arr_addr = cnt_q;
      arr_wdat = '0;
      cnt_d    = cnt_q + BITS'(1);
      if (cnt_q == '1) state_d = ST_RUN;
    end else begin
      arr_we = ~wren_n;
      arr_re = ~oen_n;
      arr_be = ~be_n;
    end
  end

  always_comb begin
    wmask = '0;
    for (int i = 0; i < LANES; i++) wmask[8*i +: 8] = {8{arr_be[i]}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  bram_be_array #(
    .WIDTH (WIDTH),
    .BITS  (BITS),
    .LANES (LANES)
  ) u_array (
    .clk    (clk),
    .we_i   (arr_we),
    .re_i   (arr_re),
    .be_i   (arr_be),
    .addr_i (arr_addr),
    .wdat_i (arr_wdat),
    .rdat_o (arr_rdat)
  );

  // Write side-info is captured only on reads so the merged result holds with the array output.
  always_comb begin
    s1_vld_d = arr_re;
    seen_d   = seen_q;
    hit_d    = hit_q;
    hmask_d  = hmask_q;
    hdat_d   = hdat_q;
    if (arr_re) begin
      seen_d  = 1'b1;
      hit_d   = arr_we;
      hmask_d = wmask;
      hdat_d  = arr_wdat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      seen_q   <= 1'b0;
      hit_q    <= 1'b0;
      hmask_q  <= '0;
      hdat_q   <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      seen_q   <= seen_d;
      hit_q    <= hit_d;
      hmask_q  <= hmask_d;
      hdat_q   <= hdat_d;
    end
  end

  // Unreset array output is masked to zero until the first read completes.
  always_comb begin
    s1_dat = '0;
    if (seen_q) begin
      if (RDW_MODE == RDW_NEW && hit_q) s1_dat = (arr_rdat & ~hmask_q) | (hdat_q & hmask_q);
      else                              s1_dat = arr_rdat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q <= 1'b0;
      s2_dat_q <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) s2_dat_q <= s1_dat;
    end
  end

  assign data_out  = OUT_REG ? s2_dat_q : s1_dat;
  assign valid_out = OUT_REG ? s2_vld_q : s1_vld_q;
  assign busy      = (state_q == ST_CLEAR);

endmodule
